pll_dyn_cfg_ctrl: RTL and testbench

Drives the dynamic reconfiguration port of the clock-phase PLL from the fabric side: the dyn_idiv, dyn_fdiv, dyn_odivN, dyn_dutyN and dyn_phaseN buses, plus pll_rst. It takes single-channel or broadcast configuration requests over a valid/ready handshake, range-checks them, and applies them to its shadow registers. It then pulses PLL reset, waits for a stable pll_lock, retries on timeout, and watches for loss of lock. It sits between the system control logic and the PLL wrapper.

---
 rtl/pll_dyn_cfg_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pll_dyn_cfg_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_dyn_cfg_ctrl.sv
// Fabric-side controller for the PLL dynamic reconfiguration port: it validates requests,
// holds the shadow registers, sequences pll_rst with a retried lock wait, and watches for lock loss.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RST    | pll_rst held high for RST_CYCLES cycles
// ST_WAIT   | pll_rst low, waiting for LOCK_STABLE cycles of lock_s, with a timeout budget
// ST_IDLE   | locked, accepting requests, watching for lock loss
// ST_FAIL   | retries exhausted: pll_rst held high, still accepting requests
module pll_dyn_cfg_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 2,
    parameter int IDIV_INIT    = 2,
    parameter int FDIV_INIT    = 32,
    parameter int ODIV_INIT    = 100,
    parameter int DUTY_INIT    = 100,
    parameter int PHASE_INIT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_ch,
    input  logic [9:0]  cfg_odiv,
    input  logic [9:0]  cfg_duty,
    input  logic [12:0] cfg_phase,
    input  logic        pll_lock,
    output logic        pll_rst,
    output logic [9:0]  dyn_idiv,
    output logic [9:0]  dyn_fdiv,
    output logic [9:0]  dyn_odiv0,
    output logic [9:0]  dyn_odiv1,
    output logic [9:0]  dyn_odiv2,
    output logic [9:0]  dyn_odiv3,
    output logic [9:0]  dyn_odiv4,
    output logic [9:0]  dyn_duty0,
    output logic [9:0]  dyn_duty1,
    output logic [9:0]  dyn_duty2,
    output logic [9:0]  dyn_duty3,
    output logic [9:0]  dyn_duty4,
    output logic [12:0] dyn_phase0,
    output logic [12:0] dyn_phase1,
    output logic [12:0] dyn_phase2,
    output logic [12:0] dyn_phase3,
    output logic [12:0] dyn_phase4,
    output logic        locked,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        lock_timeout,
    output logic        lock_lost,
    output logic [3:0]  lock_loss_cnt
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAIT = 2'd1,
        ST_IDLE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [9:0]  LP_IDIV        = 10'(IDIV_INIT);
    localparam logic [9:0]  LP_FDIV        = 10'(FDIV_INIT);
    localparam logic [9:0]  LP_ODIV        = 10'(ODIV_INIT);
    localparam logic [9:0]  LP_DUTY        = 10'(DUTY_INIT);
    localparam logic [12:0] LP_PHASE       = 13'(PHASE_INIT);
    localparam logic [15:0] LP_RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LP_TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] LP_STABLE_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [7:0]  LP_MAX_RETRY   = 8'(MAX_RETRY);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] r_stable;
    logic [15:0] w_stable_nxt;
    logic [7:0]  r_retry;
    logic [7:0]  w_retry_nxt;
    logic        r_locked;
    logic        w_locked_nxt;
    logic [3:0]  r_loss_cnt;
    logic [3:0]  w_loss_cnt_nxt;
    logic        r_lock_meta;
    logic        r_lock_s;
    logic        r_pll_rst;
    logic        r_cfg_ready;
    logic        r_done;
    logic        r_err;
    logic        r_tmo;
    logic        r_lost;
    logic        w_done;
    logic        w_err;
    logic        w_tmo;
    logic        w_lost;
    logic        w_load;
    logic        w_legal;
    logic [10:0] w_odiv_x2;

    logic [9:0]  r_odiv  [5];
    logic [9:0]  r_duty  [5];
    logic [12:0] r_phase [5];

    // duty is compared against twice the divider in 11 bits so odiv >= 512 does not wrap
    assign w_odiv_x2 = {cfg_odiv, 1'b0};
    assign w_legal   = (cfg_ch != 3'd5) && (cfg_ch != 3'd6) &&
                       (cfg_odiv != 10'd0) && (cfg_duty != 10'd0) &&
                       ({1'b0, cfg_duty} < w_odiv_x2);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stable_nxt   = r_stable;
        w_retry_nxt    = r_retry;
        w_locked_nxt   = r_locked;
        w_loss_cnt_nxt = r_loss_cnt;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_tmo          = 1'b0;
        w_lost         = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            ST_RST: begin
                w_locked_nxt = 1'b0;
                if (r_cnt == LP_RST_LAST) begin
                    w_state_nxt  = ST_WAIT;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_WAIT: begin
                w_stable_nxt = r_lock_s ? (r_stable + 16'd1) : '0;
                if (r_lock_s && (r_stable == LP_STABLE_LAST)) begin
                    w_state_nxt  = ST_IDLE;
                    w_locked_nxt = 1'b1;
                    w_done       = 1'b1;
                    w_retry_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_tmo     = 1'b1;
                    w_cnt_nxt = '0;
                    if (r_retry < LP_MAX_RETRY) begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_state_nxt = ST_RST;
                    end else begin
                        w_state_nxt = ST_FAIL;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_IDLE: begin
                if (r_locked && !r_lock_s) begin
                    w_lost       = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_RST;
                    w_cnt_nxt    = '0;
                    if (r_loss_cnt != 4'hF) begin
                        w_loss_cnt_nxt = r_loss_cnt + 4'd1;
                    end
                end
                if (cfg_valid) begin
                    if (w_legal) begin
                        w_load       = 1'b1;
                        w_state_nxt  = ST_RST;
                        w_cnt_nxt    = '0;
                        w_retry_nxt  = '0;
                        w_locked_nxt = 1'b0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_FAIL: begin
                w_locked_nxt = 1'b0;
                if (cfg_valid) begin
                    if (w_legal) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RST;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_stable    <= '0;
            r_retry     <= '0;
            r_locked    <= 1'b0;
            r_loss_cnt  <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_lost      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_odiv[i]  <= LP_ODIV;
                r_duty[i]  <= LP_DUTY;
                r_phase[i] <= LP_PHASE;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stable    <= w_stable_nxt;
            r_retry     <= w_retry_nxt;
            r_locked    <= w_locked_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            // decoded from the next state so both strobes are flop outputs
            r_pll_rst   <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_FAIL);
            r_cfg_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FAIL);
            r_done      <= w_done;
            r_err       <= w_err;
            r_tmo       <= w_tmo;
            r_lost      <= w_lost;
            for (int i = 0; i < 5; i++) begin
                if (w_load && ((cfg_ch == 3'd7) || (cfg_ch == 3'(i)))) begin
                    r_odiv[i]  <= cfg_odiv;
                    r_duty[i]  <= cfg_duty;
                    r_phase[i] <= cfg_phase;
                end
            end
        end
    end

    assign cfg_ready     = r_cfg_ready;
    assign pll_rst       = r_pll_rst;
    assign locked        = r_locked;
    assign cfg_done      = r_done;
    assign cfg_err       = r_err;
    assign lock_timeout  = r_tmo;
    assign lock_lost     = r_lost;
    assign lock_loss_cnt = r_loss_cnt;
    assign dyn_idiv      = LP_IDIV;
    assign dyn_fdiv      = LP_FDIV;
    assign dyn_odiv0     = r_odiv[0];
    assign dyn_odiv1     = r_odiv[1];
    assign dyn_odiv2     = r_odiv[2];
    assign dyn_odiv3     = r_odiv[3];
    assign dyn_odiv4     = r_odiv[4];
    assign dyn_duty0     = r_duty[0];
    assign dyn_duty1     = r_duty[1];
    assign dyn_duty2     = r_duty[2];
    assign dyn_duty3     = r_duty[3];
    assign dyn_duty4     = r_duty[4];
    assign dyn_phase0    = r_phase[0];
    assign dyn_phase1    = r_phase[1];
    assign dyn_phase2    = r_phase[2];
    assign dyn_phase3    = r_phase[3];
    assign dyn_phase4    = r_phase[4];

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: PLL lock model, request table, random requests against a
// transaction-level register model, plus retry, lock-loss and mid-lock reset sequences.
module tb_pll_dyn_cfg_ctrl;

    localparam int LOCK_DLY = 50;   // 2 us at a 40 ns clock

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [9:0]  cfg_odiv;
    logic [9:0]  cfg_duty;
    logic [12:0] cfg_phase;
    logic        pll_lock;
    logic        pll_rst;
    logic [9:0]  dyn_idiv, dyn_fdiv;
    logic [9:0]  dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_odiv4;
    logic [9:0]  dyn_duty0, dyn_duty1, dyn_duty2, dyn_duty3, dyn_duty4;
    logic [12:0] dyn_phase0, dyn_phase1, dyn_phase2, dyn_phase3, dyn_phase4;
    logic        locked, cfg_done, cfg_err, lock_timeout, lock_lost;
    logic [3:0]  lock_loss_cnt;

    logic [9:0]  o_odiv  [5];
    logic [9:0]  o_duty  [5];
    logic [12:0] o_phase [5];

    int n_vec = 0;
    int n_err = 0;
    int m_odiv [5];
    int m_duty [5];
    int m_phase[5];
    bit pll_never = 1'b0;
    bit pll_drop  = 1'b0;

    typedef struct {
        int ch;
        int odiv;
        int duty;
        int phase;
        bit err;
    } vec_t;
    vec_t tbl[10];

    pll_dyn_cfg_ctrl #(.LOCK_TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .pll_lock(pll_lock), .pll_rst(pll_rst), .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
        .dyn_odiv0(dyn_odiv0), .dyn_odiv1(dyn_odiv1), .dyn_odiv2(dyn_odiv2),
        .dyn_odiv3(dyn_odiv3), .dyn_odiv4(dyn_odiv4),
        .dyn_duty0(dyn_duty0), .dyn_duty1(dyn_duty1), .dyn_duty2(dyn_duty2),
        .dyn_duty3(dyn_duty3), .dyn_duty4(dyn_duty4),
        .dyn_phase0(dyn_phase0), .dyn_phase1(dyn_phase1), .dyn_phase2(dyn_phase2),
        .dyn_phase3(dyn_phase3), .dyn_phase4(dyn_phase4),
        .locked(locked), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .lock_timeout(lock_timeout), .lock_lost(lock_lost), .lock_loss_cnt(lock_loss_cnt)
    );

    assign o_odiv[0] = dyn_odiv0;  assign o_odiv[1] = dyn_odiv1;  assign o_odiv[2] = dyn_odiv2;
    assign o_odiv[3] = dyn_odiv3;  assign o_odiv[4] = dyn_odiv4;
    assign o_duty[0] = dyn_duty0;  assign o_duty[1] = dyn_duty1;  assign o_duty[2] = dyn_duty2;
    assign o_duty[3] = dyn_duty3;  assign o_duty[4] = dyn_duty4;
    assign o_phase[0] = dyn_phase0; assign o_phase[1] = dyn_phase1; assign o_phase[2] = dyn_phase2;
    assign o_phase[3] = dyn_phase3; assign o_phase[4] = dyn_phase4;

    always #20 clk = ~clk;

    // PLL model: locks LOCK_DLY cycles after pll_rst falls unless told not to
    initial begin
        int dly;
        dly = 0;
        pll_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (pll_rst || pll_never || pll_drop) begin
                dly = 0;
                pll_lock = 1'b0;
            end else if (dly < LOCK_DLY) begin
                dly++;
            end else begin
                pll_lock = 1'b1;
            end
        end
    end

    initial begin
        #(40 * 40000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input int ch, input int odiv, input int duty);
        return (ch <= 4 || ch == 7) && odiv > 0 && duty > 0 && duty < 2 * odiv;
    endfunction

    task automatic model_init();
        for (int c = 0; c < 5; c++) begin
            m_odiv[c] = 100; m_duty[c] = 100; m_phase[c] = 16;
        end
    endtask

    task automatic check_dyn(input string tag);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("%s_odiv%0d", tag, c), int'(o_odiv[c]), m_odiv[c]);
            chk($sformatf("%s_duty%0d", tag, c), int'(o_duty[c]), m_duty[c]);
            chk($sformatf("%s_phase%0d", tag, c), int'(o_phase[c]), m_phase[c]);
        end
    endtask

    task automatic rst_width(output int w);
        w = 0;
        for (int i = 0; i < 200; i++) begin
            if (!pll_rst) break;
            w++;
            @(negedge clk);
        end
    endtask

    task automatic wait_lock(input string tag);
        int dones;
        bit got;
        dones = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_done) dones++;
            if (locked) begin
                got = 1'b1;
                chk({tag, "_done_with_lock"}, int'(cfg_done), 1);
                break;
            end
        end
        chk({tag, "_lock_reached"}, int'(got), 1);
        chk({tag, "_done_count"}, dones, 1);
    endtask

    // Called at a negedge; drives one request and checks the cycle after the handshake.
    task automatic apply_req(input string tag, input int ch, input int odiv, input int duty,
                             input int phase, input bit exp_err, input bit from_fail,
                             input bit do_wait);
        int w;
        chk({tag, "_ready_before"}, int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_odiv  = 10'(odiv);
        cfg_duty  = 10'(duty);
        cfg_phase = 13'(phase);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        if (!exp_err) begin
            for (int c = 0; c < 5; c++) begin
                if (ch == 7 || ch == c) begin
                    m_odiv[c] = odiv; m_duty[c] = duty; m_phase[c] = phase;
                end
            end
        end
        chk({tag, "_err"}, int'(cfg_err), int'(exp_err));
        chk({tag, "_pll_rst"}, int'(pll_rst), int'(from_fail || !exp_err));
        chk({tag, "_locked"}, int'(locked), int'(exp_err && !from_fail));
        chk({tag, "_ready_after"}, int'(cfg_ready), int'(exp_err));
        check_dyn(tag);
        if (!exp_err && do_wait) begin
            rst_width(w);
            chk({tag, "_rst_width"}, w, 16);
            wait_lock(tag);
            check_dyn({tag, "_post"});
        end
    endtask

    initial begin
        int w, ch, odiv, duty, tmo, falls, seen;
        bit reached;

        tbl[0] = '{7, 200,  200,   16, 1'b0};
        tbl[1] = '{5, 100,   50,    3, 1'b1};
        tbl[2] = '{2,   0,   10,    3, 1'b1};
        tbl[3] = '{1,  50,  100,    3, 1'b1};
        tbl[4] = '{1,  50,   99,   77, 1'b0};
        tbl[5] = '{6, 100,   10,    0, 1'b1};
        tbl[6] = '{3, 100,    0,    5, 1'b1};
        tbl[7] = '{4, 512, 1023, 8191, 1'b0};
        tbl[8] = '{0,   1,    1,    0, 1'b0};
        tbl[9] = '{4, 1023, 1023, 4000, 1'b0};

        model_init();
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_odiv = '0; cfg_duty = '0; cfg_phase = '0;
        repeat (3) @(negedge clk);
        chk("reset_pll_rst", int'(pll_rst), 1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_ready", int'(cfg_ready), 0);
        chk("reset_loss_cnt", int'(lock_loss_cnt), 0);
        chk("reset_pulses", int'({cfg_done, cfg_err, lock_timeout, lock_lost}), 0);
        chk("idiv", int'(dyn_idiv), 2);
        chk("fdiv", int'(dyn_fdiv), 32);
        check_dyn("reset");

        rst_n = 1'b1;
        rst_width(w);
        chk("powerup_rst_width", w, 16);
        wait_lock("powerup");
        check_dyn("powerup");

        for (int i = 0; i < 10; i++) begin
            apply_req($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].odiv, tbl[i].duty,
                      tbl[i].phase, tbl[i].err, 1'b0, 1'b1);
        end

        for (int k = 0; k < 40; k++) begin
            ch   = int'($urandom_range(0, 7));
            odiv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 1023));
            case ($urandom_range(0, 9))
                0:       duty = 0;
                1, 2, 3, 4: begin
                    duty = 2 * odiv + int'($urandom_range(0, 2)) - 1;
                    if (duty > 1023) duty = 1023;
                    if (duty < 0) duty = 0;
                end
                default: duty = int'($urandom_range(1, 1023));
            endcase
            apply_req($sformatf("rand%0d", k), ch, odiv, duty, int'($urandom_range(0, 8191)),
                      !model_legal(ch, odiv, duty), 1'b0, 1'b1);
        end

        for (int k = 1; k <= 20; k++) begin
            pll_drop = 1'b1;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (i == 4) pll_drop = 1'b0;
                if (lock_lost) seen++;
            end
            chk($sformatf("loss%0d_pulse", k), seen, 1);
            chk($sformatf("loss%0d_cnt", k), int'(lock_loss_cnt), (k > 15) ? 15 : k);
            chk($sformatf("loss%0d_rst", k), int'(pll_rst), 1);
            wait_lock($sformatf("loss%0d", k));
        end

        apply_req("tmo_req", 0, 100, 100, 16, 1'b0, 1'b0, 1'b0);
        pll_never = 1'b1;
        tmo = 0; falls = 0; reached = 1'b0;
        w = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (lock_timeout) tmo++;
            if (w == 1 && !pll_rst) falls++;
            w = int'(pll_rst);
            if (pll_rst && cfg_ready) begin
                reached = 1'b1;
                break;
            end
        end
        chk("tmo_reached_fail", int'(reached), 1);
        chk("tmo_pulses", tmo, 3);
        chk("tmo_rst_pulses", falls, 3);
        chk("fail_locked", int'(locked), 0);
        apply_req("fail_illegal", 5, 100, 50, 1, 1'b1, 1'b1, 1'b0);
        pll_never = 1'b0;
        apply_req("fail_recover", 3, 40, 20, 1234, 1'b0, 1'b1, 1'b1);

        apply_req("midlock", 2, 300, 400, 999, 1'b0, 1'b0, 1'b0);
        rst_width(w);
        chk("midlock_rst_width", w, 16);
        repeat (5) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        model_init();
        chk("midlock_pll_rst", int'(pll_rst), 1);
        chk("midlock_locked", int'(locked), 0);
        chk("midlock_loss_cnt", int'(lock_loss_cnt), 0);
        check_dyn("midlock_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_width(w);
        chk("rerelease_rst_width", w, 16);
        wait_lock("rerelease");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
